// File: rtl/issue_scoreboard.sv
// issue_scoreboard: decode-to-execute issue register with a 32-entry write scoreboard.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   id_valid/id_ready            decode handshake; id_rs1/rs2/rd, id_use_rs1/rs2, id_regwen, id_payload
//   ex_valid/ex_ready            execute handshake; ex_rd, ex_regwen, ex_payload are registered
//   wb_valid, wb_rd              register write completion
//   flush                        kill the issue-register and decode instructions
//   outstanding, busy, err       in-flight writer count, activity flag, sticky protocol error
module issue_scoreboard #(
    parameter int PAYLOAD_W = 96,
    parameter int MAX_OUT   = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           id_valid,
    output logic                           id_ready,
    input  logic [4:0]                     id_rs1,
    input  logic [4:0]                     id_rs2,
    input  logic [4:0]                     id_rd,
    input  logic                           id_use_rs1,
    input  logic                           id_use_rs2,
    input  logic                           id_regwen,
    input  logic [PAYLOAD_W-1:0]           id_payload,
    output logic                           ex_valid,
    input  logic                           ex_ready,
    output logic [4:0]                     ex_rd,
    output logic                           ex_regwen,
    output logic [PAYLOAD_W-1:0]           ex_payload,
    input  logic                           wb_valid,
    input  logic [4:0]                     wb_rd,
    input  logic                           flush,
    output logic [$clog2(MAX_OUT+1)-1:0]   outstanding,
    output logic                           busy,
    output logic                           err
);
    localparam int CW = $clog2(MAX_OUT+1);
    logic                 ex_valid_q, ex_valid_d;
    logic [4:0]           ex_rd_q, ex_rd_d;
    logic                 ex_regwen_q, ex_regwen_d;
    logic [PAYLOAD_W-1:0] ex_payload_q, ex_payload_d;
    logic [31:0]          sb_q, sb_d;
    logic [CW-1:0]        out_q, out_d;
    logic                 err_q, err_d;
    logic [31:0]          wb_hot, pend, clr_hot, set_hot;
    logic                 ex_w, hazard, full, id_acc, ex_acc, wb_ok, dec;
    always_comb begin
        ex_w    = ex_valid_q && ex_regwen_q;
        wb_hot  = wb_valid ? (32'd1 << wb_rd) : '0;
        // A writeback this cycle bypasses its bit; the writer sitting in the issue
        // register is treated as already pending.
        pend    = (sb_q & ~wb_hot) | (ex_w ? (32'd1 << ex_rd_q) : '0);
        hazard  = (id_use_rs1 && id_rs1 != 5'd0 && pend[id_rs1])
               || (id_use_rs2 && id_rs2 != 5'd0 && pend[id_rs2])
               || (id_regwen && id_rd != 5'd0 && pend[id_rd]);
        // Uses the pre-writeback count, so a same-cycle writeback does not unblock.
        full    = ({1'b0, out_q} + (CW+1)'(ex_w)) >= (CW+1)'(MAX_OUT);
        id_ready = !flush && !hazard && !full && (!ex_valid_q || ex_ready);
        id_acc  = id_valid && id_ready;
        ex_acc  = ex_valid_q && ex_ready && !flush;
        wb_ok   = wb_valid && wb_rd != 5'd0;
        dec     = wb_ok && out_q != '0;
        clr_hot = wb_ok ? wb_hot : '0;
        set_hot = (ex_acc && ex_regwen_q) ? (32'd1 << ex_rd_q) : '0;
        // Clear before set so a simultaneous set of the same bit wins.
        sb_d    = ((sb_q & ~clr_hot) | set_hot) & ~32'd1;
        out_d   = out_q + CW'(ex_acc && ex_regwen_q) - CW'(dec);
        err_d   = err_q || (wb_valid && ((wb_rd != 5'd0 && !sb_q[wb_rd]) || out_q == '0));
        ex_valid_d   = flush ? 1'b0 : id_acc ? 1'b1 : ex_acc ? 1'b0 : ex_valid_q;
        ex_rd_d      = id_acc ? id_rd : ex_rd_q;
        ex_regwen_d  = id_acc ? (id_regwen && id_rd != 5'd0) : ex_regwen_q;
        ex_payload_d = id_acc ? id_payload : ex_payload_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q   <= 1'b0;
            ex_rd_q      <= '0;
            ex_regwen_q  <= 1'b0;
            ex_payload_q <= '0;
            sb_q         <= '0;
            out_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_rd_q      <= ex_rd_d;
            ex_regwen_q  <= ex_regwen_d;
            ex_payload_q <= ex_payload_d;
            sb_q         <= sb_d;
            out_q        <= out_d;
            err_q        <= err_d;
        end
    end
    assign ex_valid    = ex_valid_q;
    assign ex_rd       = ex_rd_q;
    assign ex_regwen   = ex_regwen_q;
    assign ex_payload  = ex_payload_q;
    assign outstanding = out_q;
    assign busy        = ex_valid_q || out_q != '0;
    assign err         = err_q;
endmodule
